// File: rtl/outbus_capture_buffer_if.sv
// Capture-buffer port bundle: observed bus, capture control, host drain port and status.
// master = host/observer side, slave = the capture buffer.
interface outbus_capture_buffer_if #(
   parameter int WIDTH = 5,
   parameter int CNTW  = 8
);
   logic [WIDTH-1:0] capBus;
   logic             start;
   logic [CNTW-1:0]  numSamp;
   logic             clear;
   logic [WIDTH-1:0] rdData;
   logic             rdValid;
   logic             rdReady;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [CNTW-1:0]  dropCnt;
   logic [15:0]      sig;

   modport master (
      output capBus, start, numSamp, clear, rdReady,
      input  rdData, rdValid, busy, done, overflow, dropCnt, sig
   );

   modport slave (
      input  capBus, start, numSamp, clear, rdReady,
      output rdData, rdValid, busy, done, overflow, dropCnt, sig
   );
endinterface

// File: rtl/outbus_capture_buffer.sv
// Samples a result bus for a programmed number of cycles into a small FWFT FIFO drained by a host.
// Optional MISR signature over the captured stream is enabled with `define CAP_MISR_EN.
module outbus_capture_buffer #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 8,
   parameter int CNTW  = 8
) (
   input logic                    clk,
   input logic                    reset,
   outbus_capture_buffer_if.slave bus
);
   localparam int         AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] CAPTURE = 1'b1;

   logic [0:0]       state;
   logic [CNTW-1:0]  remaining;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;

   logic             sampling;
   logic             pop;
   logic             push;
   logic             drop;
   logic             overflow_q;
   logic [CNTW-1:0]  drop_q;

   // clear pre-empts the capture edge: nothing is written or counted on it
   assign sampling = (state == CAPTURE) && !bus.clear;
   assign pop      = bus.rdValid && bus.rdReady;
   assign push     = sampling && ((count != FULL) || pop);
   assign drop     = sampling && !push;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
      end else if (bus.clear) begin
         state     <= IDLE;
         remaining <= '0;
      end else if (state == IDLE) begin
         if (bus.start && (bus.numSamp != '0)) begin
            state     <= CAPTURE;
            remaining <= bus.numSamp;
         end
      end else begin
         remaining <= remaining - 1'b1;
         if (remaining == CNTW'(1))
            state <= IDLE;
      end
   end

   assign bus.busy = (state == CAPTURE);
   assign bus.done = sampling && (remaining == CNTW'(1));

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= bus.capBus;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (bus.clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // Storage is not reset; gating keeps rdData at 0 whenever the FIFO is empty
   assign bus.rdValid = (count != '0);
   assign bus.rdData  = bus.rdValid ? mem[rptr] : '0;

   // ---------------------------------------------------------------- drop accounting
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else if (bus.clear) begin
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_q != '1)
            drop_q <= drop_q + 1'b1;
      end
   end

   assign bus.overflow = overflow_q;
   assign bus.dropCnt  = drop_q;

   // ---------------------------------------------------------------- signature
`ifdef CAP_MISR_EN
   logic [15:0] misr;
   logic        fb;

   assign fb = misr[15] ^ misr[13] ^ misr[12] ^ misr[10];

   // Every capture cycle folds in the bus, dropped or not; clear leaves it intact
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         misr <= 16'h0000;
      else if (sampling)
         misr <= {misr[14:0], fb} ^ {{(16-WIDTH){1'b0}}, bus.capBus};
   end

   assign bus.sig = misr;
`else
   assign bus.sig = 16'h0000;
`endif

endmodule

// File: tb/tb_outbus_capture_buffer.sv
// Self-checking bench for outbus_capture_buffer: vector table plus queue scoreboard model.
module tb_outbus_capture_buffer;
   localparam int WIDTH = 5;
   localparam int DEPTH = 8;
   localparam int CNTW  = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   outbus_capture_buffer_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();
   outbus_capture_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // behavioural model: scoreboard queue holds expected FIFO contents
   logic [WIDTH-1:0] sb [$];
   int               m_left;
   bit               m_ovf;
   int               m_drop;
   logic [15:0]      m_sig;

   typedef struct {
      bit               start;
      logic [CNTW-1:0]  num;
      logic [WIDTH-1:0] cap;
      bit               rdy;
      bit               e_busy;
      bit               e_done;
      bit               e_vld;
      logic [WIDTH-1:0] e_data;
   } vec_t;

   vec_t vt [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_left = 0;
      m_ovf  = 0;
      m_drop = 0;
      m_sig  = 16'h0000;
   endtask

   task automatic drive_idle(input bit rdy);
      bus.start   = 1'b0;
      bus.numSamp = '0;
      bus.clear   = 1'b0;
      bus.capBus  = '0;
      bus.rdReady = rdy;
   endtask

   // Check outputs against the model, advance the model, then take one clock edge
   task automatic cycle();
      bit pop;
      #1;
      pop = (sb.size() != 0) && bus.rdReady;
      chk("busy",     32'(bus.busy),     32'(m_left != 0));
      chk("done",     32'(bus.done),     32'((m_left == 1) && !bus.clear));
      chk("rdValid",  32'(bus.rdValid),  32'(sb.size() != 0));
      if (sb.size() != 0)
         chk("rdData", 32'(bus.rdData), 32'(sb[0]));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("dropCnt",  32'(bus.dropCnt),  32'(m_drop));
      chk("sig",      32'(bus.sig),      32'(m_sig));
      if (bus.clear) begin
         sb.delete();
         m_left = 0;
         m_ovf  = 0;
         m_drop = 0;
      end else begin
         if (pop)
            void'(sb.pop_front());
         if (m_left != 0) begin
`ifdef CAP_MISR_EN
            m_sig = {m_sig[14:0], m_sig[15] ^ m_sig[13] ^ m_sig[12] ^ m_sig[10]} ^ {11'b0, bus.capBus};
`endif
            if (sb.size() < DEPTH)
               sb.push_back(bus.capBus);
            else begin
               m_ovf = 1;
               if (m_drop < 255)
                  m_drop++;
            end
            m_left--;
         end else if (bus.start && (bus.numSamp != 0)) begin
            m_left = int'(bus.numSamp);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      drive_idle(1'b0);
      bus.clear = 1'b1;
      cycle();
      bus.clear = 1'b0;
   endtask

   initial begin
      vt[0] = '{1, 8'd3, 5'h00, 1, 0, 0, 0, 5'h00};
      vt[1] = '{0, 8'd0, 5'h01, 1, 1, 0, 0, 5'h00};
      vt[2] = '{0, 8'd0, 5'h02, 1, 1, 0, 1, 5'h01};
      vt[3] = '{0, 8'd0, 5'h03, 1, 1, 1, 1, 5'h02};
      vt[4] = '{0, 8'd0, 5'h00, 1, 0, 0, 1, 5'h03};
      vt[5] = '{0, 8'd0, 5'h00, 1, 0, 0, 0, 5'h00};

      // ---- reset held during activity
      model_reset();
      bus.start   = 1'b1;
      bus.numSamp = 8'd5;
      bus.clear   = 1'b0;
      bus.capBus  = 5'h1F;
      bus.rdReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_busy",    32'(bus.busy),     32'd0);
         chk("rst_rdValid", 32'(bus.rdValid),  32'd0);
         chk("rst_done",    32'(bus.done),     32'd0);
         chk("rst_dropCnt", 32'(bus.dropCnt),  32'd0);
         chk("rst_sig",     32'(bus.sig),      32'd0);
      end
      drive_idle(1'b1);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // ---- three-sample capture, table driven
      for (int i = 0; i < 6; i++) begin
         bus.start   = vt[i].start;
         bus.numSamp = vt[i].num;
         bus.capBus  = vt[i].cap;
         bus.rdReady = vt[i].rdy;
         #1;
         chk("t2_busy",    32'(bus.busy),    32'(vt[i].e_busy));
         chk("t2_done",    32'(bus.done),    32'(vt[i].e_done));
         chk("t2_rdValid", 32'(bus.rdValid), 32'(vt[i].e_vld));
         if (vt[i].e_vld)
            chk("t2_rdData", 32'(bus.rdData), 32'(vt[i].e_data));
         cycle();
      end
      chk("t2_overflow", 32'(bus.overflow), 32'd0);

      // ---- 12 samples into 8 entries with no draining
      drive_idle(1'b0);
      bus.start   = 1'b1;
      bus.numSamp = 8'd12;
      cycle();
      bus.start   = 1'b0;
      for (int k = 0; k < 12; k++) begin
         bus.capBus = 5'(k);
         cycle();
      end
      drive_idle(1'b0);
      cycle();
      chk("t3_overflow", 32'(bus.overflow), 32'd1);
      chk("t3_dropCnt",  32'(bus.dropCnt),  32'd4);
      bus.rdReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t3_drain", 32'(bus.rdData), 32'(i));
         cycle();
      end
      cycle();
      chk("t3_empty", 32'(bus.rdValid), 32'd0);

      // ---- full FIFO with push+pop in the same cycle
      do_clear();
      bus.start   = 1'b1;
      bus.numSamp = 8'd20;
      cycle();
      bus.start   = 1'b0;
      for (int k = 0; k < 20; k++) begin
         bus.capBus  = 5'(k);
         bus.rdReady = (k >= 8);
         cycle();
      end
      drive_idle(1'b1);
      chk("t4_dropCnt",  32'(bus.dropCnt),  32'd0);
      chk("t4_overflow", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("t4_drain", 32'(bus.rdData), 32'(12 + i));
         cycle();
      end
      chk("t4_empty", 32'(bus.rdValid), 32'd0);

      // ---- clear mid-capture with 5 entries held
      drive_idle(1'b0);
      bus.start   = 1'b1;
      bus.numSamp = 8'd10;
      cycle();
      bus.start   = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.capBus = 5'(k + 3);
         cycle();
      end
      chk("t5_pre_rdValid", 32'(bus.rdValid), 32'd1);
      bus.capBus = 5'h05;
      bus.clear  = 1'b1;
      cycle();
      bus.clear  = 1'b0;
      #1;
      chk("t5_rdValid",  32'(bus.rdValid),  32'd0);
      chk("t5_busy",     32'(bus.busy),     32'd0);
      chk("t5_overflow", 32'(bus.overflow), 32'd0);
      chk("t5_dropCnt",  32'(bus.dropCnt),  32'd0);
      chk("t5_done",     32'(bus.done),     32'd0);
      cycle();

      // ---- asynchronous reset in the middle of a capture
      drive_idle(1'b0);
      bus.start   = 1'b1;
      bus.numSamp = 8'd6;
      cycle();
      bus.start   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.capBus = 5'h0A;
         cycle();
      end
      #2;
      reset = 1'b1;
      #1;
      chk("ar_busy",    32'(bus.busy),    32'd0);
      chk("ar_rdValid", 32'(bus.rdValid), 32'd0);
      chk("ar_done",    32'(bus.done),    32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      // ---- signature over 1F,00,1F,00 from seed
      drive_idle(1'b1);
      bus.start   = 1'b1;
      bus.numSamp = 8'd4;
      cycle();
      bus.start   = 1'b0;
      bus.capBus  = 5'h1F; cycle();
      bus.capBus  = 5'h00; cycle();
      bus.capBus  = 5'h1F; cycle();
      bus.capBus  = 5'h00; cycle();
      drive_idle(1'b1);
      cycle();
`ifdef CAP_MISR_EN
      chk("t6_sig", 32'(bus.sig), 32'h00C6);
`else
      chk("t6_sig", 32'(bus.sig), 32'h0000);
`endif
      for (int i = 0; i < 4; i++)
         cycle();
      chk("t6_empty", 32'(bus.rdValid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
